imm_packer: RTL and testbench

- Encode-side counterpart of the 17-bit immediate sign extender. Packs {opcode, rd, rs, 32-bit immediate} requests into 32-bit instruction words for the instruction-memory loader.
- Instruction format: [31:27] op, [26:22] rd, [21:17] rs, [16:0] imm17. The decoder sign-extends imm17 from bit 16.
- Expands the LI (load-immediate) pseudo-op into one or two real instructions, emitted through a valid/ready stream. Non-LI ops are packed directly, with overflow detection.

---
 rtl/imm_packer.sv | 192 +++++++++++++++++++
 tb/tb_imm_packer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// imm_packer: packs {op, rd, rs, imm} requests into 32-bit instruction words
// ([31:27] op, [26:22] rd, [21:17] rs, [16:0] imm17) and expands the LI
// pseudo-op into ADDI, LUI or LUI+ADDI sequences on a valid/ready stream.
// Optional build macro: IMM_SAT_EN -- when defined, non-LI immediates that
// overflow 17 bits saturate instead of being truncated.
module imm_packer #(
    parameter logic [4:0] OP_LI   = 5'h1F,
    parameter logic [4:0] OP_LUI  = 5'h0F,
    parameter logic [4:0] OP_ADDI = 5'h08
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last,
    output logic        err_ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;  // no word held
    localparam logic [1:0] S_HI   = 2'd1;  // LUI word held, ADDI word pending
    localparam logic [1:0] S_LAST = 2'd2;  // final word of the request held

    // The immediate fits in 17 bits when bits 31..16 are all copies of bit 16.
    function automatic logic imm_fits(input logic [31:0] imm);
        return (imm[31:16] == {16{imm[16]}});
    endfunction

    // Upper part for LUI: rounding by bit 16 compensates for the decoder
    // sign-extending the low 17 bits; the sum wraps modulo 2^15.
    function automatic logic [14:0] calc_hi15(input logic [31:0] imm);
        return imm[31:17] + {14'd0, imm[16]};
    endfunction

    // Assemble one instruction word from its fields.
    function automatic logic [31:0] pack_word(input logic [4:0]  op,
                                              input logic [4:0]  rd,
                                              input logic [4:0]  rs,
                                              input logic [16:0] imm17);
        return {op, rd, rs, imm17};
    endfunction

    // Immediate field for a directly packed (non-LI) op.
    function automatic logic [16:0] direct_imm17(input logic [31:0] imm);
`ifdef IMM_SAT_EN
        if (imm_fits(imm)) begin
            return imm[16:0];
        end else if (imm[31]) begin
            return 17'h10000;
        end else begin
            return 17'h0FFFF;
        end
`else
        return imm[16:0];
`endif
    endfunction

    logic [1:0]  state_r;
    logic        out_valid_r;
    logic [31:0] out_word_r;
    logic        out_last_r;
    logic        err_ovf_r;
    logic [31:0] pend_word_r;

    logic        accept_s;
    logic        fits_s;
    logic [14:0] hi15_s;
    logic [16:0] lo17_s;

    logic [1:0]  req_state_s;
    logic [31:0] req_word_s;
    logic        req_last_s;
    logic        req_err_s;
    logic [31:0] req_pend_s;

    logic [1:0]  state_nx_s;
    logic        valid_nx_s;
    logic [31:0] word_nx_s;
    logic        last_nx_s;
    logic        err_nx_s;
    logic [31:0] pend_nx_s;

    assign in_ready  = (state_r == S_IDLE) || ((state_r == S_LAST) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign fits_s    = imm_fits(in_imm);
    assign hi15_s    = calc_hi15(in_imm);
    assign lo17_s    = in_imm[16:0];

    assign out_valid = out_valid_r;
    assign out_word  = out_word_r;
    assign out_last  = out_last_r;
    assign err_ovf   = err_ovf_r;

    // Decode the incoming request into its first word, follow-up word and target state.
    always_comb begin
        req_state_s = S_LAST;
        req_word_s  = 32'd0;
        req_last_s  = 1'b1;
        req_err_s   = 1'b0;
        req_pend_s  = 32'd0;
        if (in_op == OP_LI) begin
            if (fits_s) begin
                req_word_s = pack_word(OP_ADDI, in_rd, 5'd0, lo17_s);
            end else if (lo17_s == 17'd0) begin
                req_word_s = pack_word(OP_LUI, in_rd, 5'd0, {2'b00, hi15_s});
            end else begin
                req_word_s  = pack_word(OP_LUI, in_rd, 5'd0, {2'b00, hi15_s});
                req_last_s  = 1'b0;
                req_state_s = S_HI;
                req_pend_s  = pack_word(OP_ADDI, in_rd, in_rd, lo17_s);
            end
        end else begin
            req_word_s = pack_word(in_op, in_rd, in_rs, direct_imm17(in_imm));
            req_err_s  = !fits_s;
        end
    end

    // Next-state and next-output selection for the output holding stage.
    always_comb begin
        state_nx_s = state_r;
        valid_nx_s = out_valid_r;
        word_nx_s  = out_word_r;
        last_nx_s  = out_last_r;
        err_nx_s   = err_ovf_r;
        pend_nx_s  = pend_word_r;
        case (state_r)
            S_IDLE, S_LAST: begin
                if (accept_s) begin
                    state_nx_s = req_state_s;
                    valid_nx_s = 1'b1;
                    word_nx_s  = req_word_s;
                    last_nx_s  = req_last_s;
                    err_nx_s   = req_err_s;
                    pend_nx_s  = req_pend_s;
                end else if ((state_r == S_LAST) && out_ready) begin
                    state_nx_s = S_IDLE;
                    valid_nx_s = 1'b0;
                end else begin
                    state_nx_s = state_r;
                    valid_nx_s = out_valid_r;
                end
            end
            S_HI: begin
                if (out_ready) begin
                    state_nx_s = S_LAST;
                    valid_nx_s = 1'b1;
                    word_nx_s  = pend_word_r;
                    last_nx_s  = 1'b1;
                    err_nx_s   = 1'b0;
                    pend_nx_s  = 32'd0;
                end else begin
                    state_nx_s = S_HI;
                    valid_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                valid_nx_s = 1'b0;
                word_nx_s  = 32'd0;
                last_nx_s  = 1'b0;
                err_nx_s   = 1'b0;
                pend_nx_s  = 32'd0;
            end
        endcase
    end

    // State and output registers; reset drops any pending ADDI word at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            out_word_r  <= 32'd0;
            out_last_r  <= 1'b0;
            err_ovf_r   <= 1'b0;
            pend_word_r <= 32'd0;
        end else begin
            state_r     <= state_nx_s;
            out_valid_r <= valid_nx_s;
            out_word_r  <= word_nx_s;
            out_last_r  <= last_nx_s;
            err_ovf_r   <= err_nx_s;
            pend_word_r <= pend_nx_s;
        end
    end

endmodule

// File: tb/tb_imm_packer.sv
// Directed, table-driven bench for imm_packer with hand-computed words,
// plus sequences for backpressure and reset during a two-word expansion.
module tb_imm_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;
    logic        err_ovf;

    int tests_run;
    int tests_failed;

    imm_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .err_ovf   (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [31:0] imm;
        logic        two;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request just after a rising edge and hold it until accepted.
    task automatic apply_req(input logic [4:0] op, input logic [4:0] rd,
                             input logic [4:0] rs, input logic [31:0] imm);
        int n;
        in_op    = op;
        in_rd    = rd;
        in_rs    = rs;
        in_imm   = imm;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] hold_word;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 5'd0;
        in_rd     = 5'd0;
        in_rs     = 5'd0;
        in_imm    = 32'd0;
        out_ready = 1'b1;

        // op, rd, rs, imm, two, w0, w1, err
        vecs[0] = '{5'h1F, 5'd3, 5'd31, 32'h0000_1234, 1'b0, 32'h40C0_1234, 32'h0, 1'b0};
        vecs[1] = '{5'h1F, 5'd5, 5'd0,  32'h1234_5678, 1'b1, 32'h7940_091A, 32'h414A_5678, 1'b0};
        vecs[2] = '{5'h1F, 5'd1, 5'd0,  32'h7FFF_FFFF, 1'b1, 32'h7840_4000, 32'h4043_FFFF, 1'b0};
        vecs[3] = '{5'h1F, 5'd2, 5'd0,  32'h0002_0000, 1'b0, 32'h7880_0001, 32'h0, 1'b0};
        vecs[4] = '{5'h1F, 5'd4, 5'd0,  32'hFFFF_8000, 1'b0, 32'h4101_8000, 32'h0, 1'b0};
`ifdef IMM_SAT_EN
        vecs[5] = '{5'h02, 5'd4, 5'd6,  32'h0003_0000, 1'b0, 32'h110C_FFFF, 32'h0, 1'b1};
        vecs[6] = '{5'h03, 5'd1, 5'd2,  32'hFFFE_0000, 1'b0, 32'h1845_0000, 32'h0, 1'b1};
`else
        vecs[5] = '{5'h02, 5'd4, 5'd6,  32'h0003_0000, 1'b0, 32'h110D_0000, 32'h0, 1'b1};
        vecs[6] = '{5'h03, 5'd1, 5'd2,  32'hFFFE_0000, 1'b0, 32'h1844_0000, 32'h0, 1'b1};
`endif
        vecs[7] = '{5'h08, 5'd7, 5'd9,  32'hFFFF_FFFF, 1'b0, 32'h41D3_FFFF, 32'h0, 1'b0};

        // Reset values while rst is held.
        #3;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_word", out_word, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_err", {31'd0, err_ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven requests, back to back, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            apply_req(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm);
            chk($sformatf("v%0d_valid0", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_word0", i), out_word, vecs[i].w0);
            chk($sformatf("v%0d_last0", i), {31'd0, out_last}, {31'd0, !vecs[i].two});
            chk($sformatf("v%0d_err", i), {31'd0, err_ovf}, {31'd0, vecs[i].err});
            if (vecs[i].two) begin
                chk($sformatf("v%0d_hi_in_ready", i), {31'd0, in_ready}, 32'd0);
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_word1", i), out_word, vecs[i].w1);
                chk($sformatf("v%0d_last1", i), {31'd0, out_last}, 32'd1);
                chk($sformatf("v%0d_err1", i), {31'd0, err_ovf}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        chk("drain_idle", {31'd0, out_valid}, 32'd0);

        // Backpressure on the LUI word for five cycles.
        out_ready = 1'b0;
        apply_req(5'h1F, 5'd5, 5'd0, 32'h1234_5678);
        hold_word = out_word;
        chk("bp_first", hold_word, 32'h7940_091A);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_word_c%0d", c), out_word, 32'h7940_091A);
            chk($sformatf("bp_last_c%0d", c), {31'd0, out_last}, 32'd0);
            chk($sformatf("bp_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_word", out_word, 32'h414A_5678);
        chk("bp_release_last", {31'd0, out_last}, 32'd1);
        // Stall the final word: in_ready must drop without out_ready.
        out_ready = 1'b0;
        #1;
        chk("last_stall_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("last_stall_word", out_word, 32'h414A_5678);
        chk("last_stall_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("last_drain", {31'd0, out_valid}, 32'd0);

        // Reset during S_HI drops the pending ADDI word.
        out_ready = 1'b0;
        apply_req(5'h1F, 5'd5, 5'd0, 32'h1234_5678);
        chk("rhi_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rhi_async_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        apply_req(5'h1F, 5'd3, 5'd0, 32'h0000_1234);
        chk("rhi_after_word", out_word, 32'h40C0_1234);
        chk("rhi_after_last", {31'd0, out_last}, 32'd1);
        @(posedge clk);
        #1;
        chk("rhi_no_extra", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
